spi_reg_engine: RTL

SPI_REG_ENGINE -- requirements
Module: spi_reg_engine

---
 rtl/spi_reg_engine_if.sv | 31 +++
 rtl/spi_reg_engine.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_engine_if.sv
// Runtime request/response bus of spi_reg_engine.
//   req_valid/req_ready : per-channel handshake (NUM_CH bits)
//   req_rnw             : per-channel 1 = read, 0 = write
//   req_addr/req_data   : packed per-channel fields, channel 0 in the LSBs
//   rsp_valid           : one-cycle completion pulse
//   rsp_ch/rsp_data     : completing channel and captured read data
// master = request source, slave = engine.
interface spi_reg_engine_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_CH = 2
);
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH-1:0]        req_rnw;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*DATA_W-1:0] req_data;
  logic                     rsp_valid;
  logic [2:0]               rsp_ch;
  logic [DATA_W-1:0]        rsp_data;

  modport master (
    output req_valid, req_rnw, req_addr, req_data,
    input  req_ready, rsp_valid, rsp_ch, rsp_data
  );

  modport slave (
    input  req_valid, req_rnw, req_addr, req_data,
    output req_ready, rsp_valid, rsp_ch, rsp_data
  );
endinterface

// File: rtl/spi_reg_engine.sv
// SPI register engine: replays an init table of write frames, then serves
// round-robin read/write requests from NUM_CH channels as SPI frames.
//   clk, reset      : clock, asynchronous active-high reset
//   o_sclk/o_sdio   : SPI clock and MOSI; o_sen_n active-low select
//   i_sdo           : SPI MISO
//   o_init_idx      : init-table index being fetched
//   i_init_entry    : {write_enable, addr, data} for o_init_idx
//   i_reinit        : pulse requesting an init-table replay
//   o_init_done     : init pass complete
//   bus             : request/response interface (slave side)
module spi_reg_engine #(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_INIT = 20,
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned CLK_DIV  = 1,
  parameter int unsigned GAP      = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       o_sclk,
  output logic                       o_sdio,
  output logic                       o_sen_n,
  input  logic                       i_sdo,
  output logic [7:0]                 o_init_idx,
  input  logic [ADDR_W+DATA_W:0]     i_init_entry,
  input  logic                       i_reinit,
  output logic                       o_init_done,
  spi_reg_engine_if.slave            bus
);
  localparam int unsigned FW    = 1 + ADDR_W + DATA_W;
  localparam int unsigned BIT_W = $clog2(FW);
  localparam int unsigned DIV_W = 8;
  localparam int unsigned GAP_W = 4;
  localparam logic [7:0]  LAST_IDX = 8'(NUM_INIT - 1);

  typedef enum logic [1:0] {S_INIT, S_ARB, S_SHIFT, S_GAP} state_t;

  state_t              r_state, w_state_nxt;
  logic [7:0]          r_init_idx, w_init_idx_nxt;
  logic                r_init_done, w_init_done_nxt;
  logic                r_reinit_pend, w_reinit_pend_nxt;
  logic [2:0]          r_rr_ptr, w_rr_ptr_nxt;
  logic [2:0]          r_grant, w_grant_nxt;
  logic                r_frame_init, w_frame_init_nxt;
  logic                r_init_last, w_init_last_nxt;
  logic                r_rnw, w_rnw_nxt;
  logic [FW-1:0]       r_shift, w_shift_nxt;
  logic [BIT_W-1:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [DIV_W-1:0]    r_div_cnt, w_div_cnt_nxt;
  logic [GAP_W-1:0]    r_gap_cnt, w_gap_cnt_nxt;
  logic                r_sclk, w_sclk_nxt;
  logic                r_sen_n, w_sen_n_nxt;
  logic                r_sdio, w_sdio_nxt;
  logic [NUM_CH-1:0]   r_req_ready, w_req_ready_nxt;
  logic                r_rsp_valid, w_rsp_valid_nxt;
  logic [2:0]          r_rsp_ch, w_rsp_ch_nxt;
  logic [DATA_W-1:0]   r_rsp_data, w_rsp_data_nxt;

  logic [7:0]          w_valid8, w_rnw8;
  logic [ADDR_W-1:0]   w_addr_a [8];
  logic [DATA_W-1:0]   w_data_a [8];
  logic [DATA_W-1:0]   w_sel_data;
  logic [FW-1:0]       w_frame_rt;
  logic [FW-1:0]       w_shifted;
  logic                w_any;
  logic [2:0]          w_pick, w_cand;

  // Channel field muxing and round-robin pick starting at r_rr_ptr
  always_comb begin
    w_valid8 = 8'(bus.req_valid);
    w_rnw8   = 8'(bus.req_rnw);
    for (int c = 0; c < 8; c++) begin
      w_addr_a[c] = '0;
      w_data_a[c] = '0;
    end
    for (int c = 0; c < int'(NUM_CH); c++) begin
      w_addr_a[c] = bus.req_addr[c*ADDR_W +: ADDR_W];
      w_data_a[c] = bus.req_data[c*DATA_W +: DATA_W];
    end
    w_sel_data = w_rnw8[r_grant] ? {DATA_W{1'b0}} : w_data_a[r_grant];
    w_frame_rt = {w_rnw8[r_grant], w_addr_a[r_grant], w_sel_data};
    w_shifted  = {r_shift[FW-2:0], i_sdo};
    w_any  = 1'b0;
    w_pick = '0;
    w_cand = '0;
    // Descending scan so the closest candidate after the pointer wins
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      w_cand = 3'((int'(r_rr_ptr) + i) % int'(NUM_CH));
      if (w_valid8[w_cand]) begin
        w_any  = 1'b1;
        w_pick = w_cand;
      end
    end
  end

  // Next-state and output logic
  always_comb begin
    w_state_nxt       = r_state;
    w_init_idx_nxt    = r_init_idx;
    w_init_done_nxt   = r_init_done;
    w_reinit_pend_nxt = r_reinit_pend | i_reinit;
    w_rr_ptr_nxt      = r_rr_ptr;
    w_grant_nxt       = r_grant;
    w_frame_init_nxt  = r_frame_init;
    w_init_last_nxt   = r_init_last;
    w_rnw_nxt         = r_rnw;
    w_shift_nxt       = r_shift;
    w_bit_cnt_nxt     = r_bit_cnt;
    w_div_cnt_nxt     = r_div_cnt;
    w_gap_cnt_nxt     = r_gap_cnt;
    w_sclk_nxt        = r_sclk;
    w_sen_n_nxt       = r_sen_n;
    w_req_ready_nxt   = '0;
    w_rsp_valid_nxt   = 1'b0;
    w_rsp_ch_nxt      = r_rsp_ch;
    w_rsp_data_nxt    = r_rsp_data;

    case (r_state)
      S_INIT: begin
        if (i_init_entry[FW-1]) begin
          w_shift_nxt      = {1'b0, i_init_entry[FW-2:0]};
          w_rnw_nxt        = 1'b0;
          w_frame_init_nxt = 1'b1;
          w_init_last_nxt  = (r_init_idx == LAST_IDX);
          w_state_nxt      = S_SHIFT;
          w_sen_n_nxt      = 1'b0;
          w_sclk_nxt       = 1'b0;
          w_div_cnt_nxt    = '0;
          w_bit_cnt_nxt    = BIT_W'(FW - 1);
          if (r_init_idx != LAST_IDX) w_init_idx_nxt = r_init_idx + 8'd1;
        end else if (r_init_idx == LAST_IDX) begin
          w_init_done_nxt = 1'b1;
          w_state_nxt     = S_ARB;
        end else begin
          w_init_idx_nxt = r_init_idx + 8'd1;
        end
      end

      S_ARB: begin
        if (|r_req_ready) begin
          // Ready cycle: the master still holds its fields, latch them
          w_rnw_nxt        = w_rnw8[r_grant];
          w_shift_nxt      = w_frame_rt;
          w_frame_init_nxt = 1'b0;
          w_rr_ptr_nxt     = (r_grant == 3'(NUM_CH - 1)) ? 3'd0 : r_grant + 3'd1;
          w_state_nxt      = S_SHIFT;
          w_sen_n_nxt      = 1'b0;
          w_sclk_nxt       = 1'b0;
          w_div_cnt_nxt    = '0;
          w_bit_cnt_nxt    = BIT_W'(FW - 1);
        end else if (r_reinit_pend) begin
          w_reinit_pend_nxt = i_reinit;
          w_init_done_nxt   = 1'b0;
          w_init_idx_nxt    = '0;
          w_state_nxt       = S_INIT;
        end else if (w_any) begin
          w_grant_nxt     = w_pick;
          w_req_ready_nxt = NUM_CH'(1) << w_pick;
        end
      end

      S_SHIFT: begin
        if (r_div_cnt == DIV_W'(CLK_DIV - 1)) begin
          w_div_cnt_nxt = '0;
          if (!r_sclk) begin
            w_sclk_nxt = 1'b1;
          end else begin
            w_sclk_nxt  = 1'b0;
            w_shift_nxt = w_shifted;
            if (r_bit_cnt == '0) begin
              w_sen_n_nxt   = 1'b1;
              w_state_nxt   = S_GAP;
              w_gap_cnt_nxt = '0;
              if (!r_frame_init) begin
                w_rsp_valid_nxt = 1'b1;
                w_rsp_ch_nxt    = r_grant;
                w_rsp_data_nxt  = r_rnw ? w_shifted[DATA_W-1:0] : '0;
              end
            end else begin
              w_bit_cnt_nxt = r_bit_cnt - BIT_W'(1);
            end
          end
        end else begin
          w_div_cnt_nxt = r_div_cnt + 8'd1;
        end
      end

      S_GAP: begin
        if (r_gap_cnt == GAP_W'(GAP - 1)) begin
          if (r_frame_init && !r_init_last) begin
            w_state_nxt = S_INIT;
          end else begin
            if (r_frame_init) w_init_done_nxt = 1'b1;
            w_state_nxt = S_ARB;
          end
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 4'd1;
        end
      end

      default: w_state_nxt = S_INIT;
    endcase

    w_sdio_nxt = (w_state_nxt == S_SHIFT) ? w_shift_nxt[FW-1] : 1'b0;
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_INIT;
      r_init_idx    <= '0;
      r_init_done   <= 1'b0;
      r_reinit_pend <= 1'b0;
      r_rr_ptr      <= '0;
      r_grant       <= '0;
      r_frame_init  <= 1'b0;
      r_init_last   <= 1'b0;
      r_rnw         <= 1'b0;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_div_cnt     <= '0;
      r_gap_cnt     <= '0;
      r_sclk        <= 1'b0;
      r_sen_n       <= 1'b1;
      r_sdio        <= 1'b0;
      r_req_ready   <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_ch      <= '0;
      r_rsp_data    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_init_idx    <= w_init_idx_nxt;
      r_init_done   <= w_init_done_nxt;
      r_reinit_pend <= w_reinit_pend_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_grant       <= w_grant_nxt;
      r_frame_init  <= w_frame_init_nxt;
      r_init_last   <= w_init_last_nxt;
      r_rnw         <= w_rnw_nxt;
      r_shift       <= w_shift_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_div_cnt     <= w_div_cnt_nxt;
      r_gap_cnt     <= w_gap_cnt_nxt;
      r_sclk        <= w_sclk_nxt;
      r_sen_n       <= w_sen_n_nxt;
      r_sdio        <= w_sdio_nxt;
      r_req_ready   <= w_req_ready_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_ch      <= w_rsp_ch_nxt;
      r_rsp_data    <= w_rsp_data_nxt;
    end
  end

  assign o_sclk        = r_sclk;
  assign o_sdio        = r_sdio;
  assign o_sen_n       = r_sen_n;
  assign o_init_idx    = r_init_idx;
  assign o_init_done   = r_init_done;
  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_ch    = r_rsp_ch;
  assign bus.rsp_data  = r_rsp_data;
endmodule
